// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_onehot_arbiter
//  Description : Round-robin arbiter with a registered one-hot grant that
//                shares one valid/ready channel and holds it for whole bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_onehot_arbiter #(
    parameter int NR_REQ     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NR_REQ-1:0]            req_valid,
    input  logic [NR_REQ-1:0]            req_last,
    input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NR_REQ-1:0]            req_ready,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [NR_REQ-1:0]            grant,
    output logic [IDX_WIDTH-1:0]         grant_idx,
    output logic                         busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NR_REQ - 1);
    localparam logic [NR_REQ-1:0]    c_one      = NR_REQ'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NR_REQ-1:0]     r_grant;
    logic [NR_REQ-1:0]     w_grant_nxt;
    logic [IDX_WIDTH-1:0]  r_grant_idx;
    logic [IDX_WIDTH-1:0]  w_grant_idx_nxt;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic [IDX_WIDTH-1:0]  w_ptr_nxt;

    logic [NR_REQ-1:0]     w_mask;
    logic [NR_REQ-1:0]     w_req_hi;
    logic [NR_REQ-1:0]     w_pick;
    logic [NR_REQ-1:0]     w_win_oh;
    logic [IDX_WIDTH-1:0]  w_win_idx;
    logic                  w_any_req;

    logic [DATA_WIDTH-1:0] w_data_gated [NR_REQ];
    logic [DATA_WIDTH-1:0] w_data_or;
    logic                  w_fwd_valid;
    logic                  w_fwd_last;
    logic                  w_burst_done;

    // Requesters at or above ptr take priority; otherwise wrap to the lowest index.
    assign w_mask    = ~((c_one << r_ptr) - c_one);
    assign w_req_hi  = req_valid & w_mask;
    assign w_pick    = (|w_req_hi) ? w_req_hi : req_valid;
    assign w_win_oh  = w_pick & (~w_pick + c_one);
    assign w_any_req = |req_valid;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_idx = w_win_idx | IDX_WIDTH'(i);
            end
        end
    end

    // Grant-gated AND-OR mux; an all-zero grant yields zero rather than X.
    for (genvar i = 0; i < NR_REQ; i++) begin : g_mux
        assign w_data_gated[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}};
    end

    always_comb begin
        w_data_or = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            w_data_or = w_data_or | w_data_gated[i];
        end
    end

    assign w_fwd_valid  = |(req_valid & r_grant);
    assign w_fwd_last   = |(req_last & r_grant);
    assign w_burst_done = w_fwd_valid & out_ready & w_fwd_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_grant_idx_nxt = r_grant_idx;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt     = w_win_oh;
                    w_grant_idx_nxt = w_win_idx;
                    w_state_nxt     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The winner drops to lowest priority once its burst completes.
                if (w_burst_done) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (r_grant_idx == c_last_idx) ? '0 : r_grant_idx + IDX_WIDTH'(1);
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign busy      = (r_state == ST_BUSY);
    assign out_valid = w_fwd_valid;
    assign out_last  = w_fwd_last;
    assign out_data  = w_data_or;
    assign req_ready = r_grant & {NR_REQ{out_ready}};

endmodule
`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_onehot_arbiter
//  Description : Self-checking bench for rr_onehot_arbiter with a beat
//                scoreboard and per-requester source queues.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_onehot_arbiter;

    localparam int NR_REQ     = 4;
    localparam int DATA_WIDTH = 32;
    localparam int IDX_WIDTH  = 2;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic [NR_REQ-1:0]            req_valid = '0;
    logic [NR_REQ-1:0]            req_last = '0;
    logic [NR_REQ*DATA_WIDTH-1:0] req_data = '0;
    logic [NR_REQ-1:0]            req_ready;
    logic                         out_valid;
    logic                         out_last;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_ready = 1'b1;
    logic [NR_REQ-1:0]            grant;
    logic [IDX_WIDTH-1:0]         grant_idx;
    logic                         busy;

    beat_t       src_q [NR_REQ][$];
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [NR_REQ-1:0] stall = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    rr_onehot_arbiter #(
        .NR_REQ     (NR_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_burst(input int r, input int n, input logic [DATA_WIDTH-1:0] base);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            b.last = (k == n - 1);
            b.data = base + DATA_WIDTH'(k);
            src_q[r].push_back(b);
            e.idx  = IDX_WIDTH'(r);
            e.last = b.last;
            e.data = b.data;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_left", exp_q.size(), 0);
        wait_neg(2);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_ready"}, req_ready, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Requester models: present the head of each source queue after every edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR_REQ; i++) begin
            if (src_q[i].size() > 0 && !stall[i]) begin
                req_valid[i] = 1'b1;
                req_last[i]  = src_q[i][0].last;
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = src_q[i][0].data;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Sample just before each rising edge: invariants, handshakes, scoreboard.
    always @(negedge clk) begin
        #4;
        chk("inv_onehot0", $onehot0(grant), 1);
        chk("inv_busy", busy, |grant);
        chk("inv_ready", |(req_ready & ~grant), 0);
        for (int i = 0; i < NR_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", out_data, mon_e.data);
                chk("beat_last", out_last, mon_e.last);
                chk("beat_src", grant_idx, mon_e.idx);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR_REQ-1:0] seq [9];
        seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // Reset values
        wait_neg(1);
        chk_idle("reset");
        chk("reset_idx", grant_idx, 0);
        wait_neg(2);
        rst = 1'b0;

        // No requests: stays idle
        for (int k = 0; k < 10; k++) begin
            wait_neg(1);
            chk_idle("idle");
        end

        // 3-beat burst from requester 2
        push_burst(2, 3, 32'hA);
        wait_neg(1);
        chk("b2_latency", grant, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            wait_neg(1);
            chk("b2_grant", grant, 4'b0100);
        end
        wait_neg(1);
        chk("b2_release", grant, 4'b0000);
        chk("b2_idx_hold", grant_idx, 2);
        drain(20);

        // Fresh reset, then all four continuously requesting single beats
        rst = 1'b1;
        wait_neg(2);
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR_REQ; i++) begin
                push_burst(i, 1, 32'h1000 + 32'(r * 16 + i));
            end
        end
        wait_neg(1);
        for (int k = 0; k < 9; k++) begin
            wait_neg(1);
            chk("rr_seq", grant, seq[k]);
        end
        drain(40);

        // Backpressure and mid-burst valid drop on requester 1, with 3 waiting
        push_burst(1, 3, 32'h100);
        push_burst(3, 1, 32'h300);
        wait_neg(2);
        chk("bp_grant", grant, 4'b0010);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_neg(1);
            chk("bp_hold", grant, 4'b0010);
            chk("bp_r3_ready", req_ready[3], 0);
        end
        out_ready = 1'b1;
        stall[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_neg(1);
            chk("drop_hold", grant, 4'b0010);
            chk("drop_valid", out_valid, 0);
        end
        stall[1] = 1'b0;
        drain(40);

        // Asynchronous reset during beat 2 of a 4-beat burst from requester 2
        push_burst(2, 4, 32'h200);
        wait_neg(2);
        chk("ar_grant", grant, 4'b0100);
        wait_neg(1);
        rst = 1'b1;
        #1;
        chk_idle("ar_now");
        chk("ar_idx", grant_idx, 0);
        for (int i = 0; i < NR_REQ; i++) src_q[i].delete();
        exp_q.delete();
        wait_neg(1);
        push_burst(2, 1, 32'h2A0);
        push_burst(3, 1, 32'h3A0);
        wait_neg(1);
        rst = 1'b0;
        wait_neg(1);
        chk("ar_after", grant, 4'b0100);
        drain(40);

        // Wrap: requester 2 leaves ptr at 3, then 0 and 1 request
        push_burst(2, 1, 32'h2B0);
        drain(20);
        push_burst(0, 1, 32'h0B0);
        push_burst(1, 1, 32'h1B0);
        wait_neg(2);
        chk("wrap_grant", grant, 4'b0001);
        drain(20);
        chk("wrap_idx_hold", grant_idx, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready channel among NR_REQ requesters.
- Issues a registered one-hot grant vector that directly drives the one-hot select of the shared data mux.
- Holds the grant for a multi-beat transfer until the beat flagged last completes.
- Sits between bus masters (IFU/LSU-style clients) and a single shared port.

Parameters:
- NR_REQ, 4, number of requesters (>=1).
- DATA_WIDTH, 32, payload width per beat.
- IDX_WIDTH, (NR_REQ>1 ? $clog2(NR_REQ) : 1), width of the binary grant index.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NR_REQ  per-requester beat valid.
- req_last  input  NR_REQ  per-requester final-beat flag, qualified by req_valid.
- req_data  input  NR_REQ*DATA_WIDTH  requester i payload at [DATA_WIDTH*i +: DATA_WIDTH].
- req_ready  output  NR_REQ  per-requester ready.
- out_valid  output  1  shared channel valid.
- out_last  output  1  shared channel last.
- out_data  output  DATA_WIDTH  shared channel payload.
- out_ready  input  1  downstream ready.
- grant  output  NR_REQ  registered one-hot grant; all-zero when idle.
- grant_idx  output  IDX_WIDTH  binary index of the grant; holds the last winner when idle.
- busy  output  1  high while in state BUSY.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, grant_idx=0, ptr=0, busy=0, out_valid=0, req_ready=0.
- State IDLE:
  - All req_ready=0 and out_valid=0.
  - If any req_valid is high at a clock edge, select the first set req_valid scanning indices ptr, ptr+1, ... NR_REQ-1, 0, ... (wrap).
  - Load grant=1<<win and grant_idx=win, then go to BUSY.
  - Requester vector evaluated at edge t gives grant visible in cycle t+1 (1-cycle arbitration latency).
- State BUSY (g = grant_idx), purely combinational forwarding:
  - out_valid = req_valid[g], out_last = req_last[g], out_data = req_data[g].
  - req_ready[g] = out_ready; every other req_ready = 0.
  - Beat handshake = out_valid & out_ready.
  - Handshake with out_last=1: ptr <= (g==NR_REQ-1) ? 0 : g+1, grant <= 0, go to IDLE.
  - Handshake with out_last=0: stay in BUSY with the same grant.
  - req_valid[g] low mid-burst: no abort; stay in BUSY, out_valid=0, wait indefinitely.
- Turnaround: one mandatory IDLE bubble between bursts. Max throughput is a 1-beat burst every 2 cycles; back-to-back beats within a burst run at 1 per cycle.
- Fairness: the winner becomes lowest priority next round. With all NR_REQ requesting continuously, each is granted exactly once per NR_REQ bursts.
- Ungranted requesters are never ready, so they must hold valid/data stable (standard valid/ready rule).
- out_data when out_valid=0: don't care, but must equal req_data[g] while BUSY (X-free in simulation).
- Reset asserted mid-burst: immediate return to reset values. The partial burst is dropped and ptr returns to 0.
- NR_REQ=1: grant toggles 0/1 across IDLE/BUSY; grant_idx is always 0.
- Invariants (assert in bench):
  - $onehot0(grant) at all times.
  - busy == |grant.
  - No req_ready bit is high outside grant.

Test Plan:
- Reset then req_valid=4'b0000 for 10 cycles -> grant=0, out_valid=0, all req_ready=0, busy=0 throughout.
- req_valid=4'b0100, 3-beat burst (data 0xA,0xB,0xC, last on 0xC), out_ready=1 -> grant=4'b0100 the cycle after; beats accepted on 3 consecutive cycles; grant=0 the cycle after 0xC; ptr=3.
- All four requesting single-beat bursts continuously, out_ready=1 -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; each requester gets 1 beat per 8 cycles.
- Granted requester 1 in a burst, out_ready=0 for 5 cycles plus req_valid[1] dropped for 2 cycles, while req_valid[3]=1 -> grant stays 0010, req_ready[3]=0, no data lost; burst completes; requester 3 granted next.
- Assert rst asynchronously (mid-cycle) during beat 2 of a 4-beat burst from requester 2 -> grant=0, busy=0, req_ready=0 immediately. After release with req_valid=4'b1100, requester 2 wins (ptr=0 scan).
- Wrap case: ptr=3 after requester 2 finishes, req_valid=4'b0011 -> requester 0 granted (wrap past 3), then requester 1.
